// File: rtl/p_reg_reader.sv
// p_reg_reader: streams a byte matrix out as 32-bit words, four pixels per
// word, pixel index fastest, over a valid/ready handshake.
//
// Ports
//   clk, rst     : rising-edge clock, synchronous active-high reset
//   start        : one-cycle request to stream the whole matrix (IDLE only)
//   clear        : abort; returns to IDLE with no done pulse
//   matrix_in    : [col][pixel] bytes, sampled live when a word is loaded
//   out_data     : {m[c][p+3], m[c][p+2], m[c][p+1], m[c][p]}
//   out_valid    : out_data valid (same as busy)
//   out_ready    : consumer accepts the word on this edge
//   pixel_iter   : pixel index p of the current word (multiple of 4)
//   eigen_iter   : column index c of the current word
//   busy         : high while streaming
//   done         : one-cycle pulse after the last word transfers
module p_reg_reader #(
  parameter int NUM_PIXELS = 160,
  parameter int COLS_SIZE  = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       clear,
  input  logic [COLS_SIZE-1:0][NUM_PIXELS-1:0][7:0]  matrix_in,
  output logic [31:0]                                out_data,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [15:0]                                pixel_iter,
  output logic [3:0]                                 eigen_iter,
  output logic                                       busy,
  output logic                                       done
);

  localparam int NUM_GROUPS = NUM_PIXELS / 4;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] pix_q, pix_d;
  logic [3:0]  col_q, col_d;
  logic [31:0] data_q, data_d;
  logic [31:0] word_sel;
  logic        load;     // fetch the word at the next indices
  logic        zero;     // leaving STREAM: blank the data register
  logic        last_word;
  logic        last_pix;

  assign last_pix  = (pix_q == 16'(NUM_PIXELS - 4));
  assign last_word = last_pix && (col_q == 4'(COLS_SIZE - 1));

  // Next-state / index logic.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    col_d   = col_q;
    load    = 1'b0;
    zero    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // clear beats start in IDLE
        if (start && !clear) begin
          state_d = S_STREAM;
          pix_d   = '0;
          col_d   = '0;
          load    = 1'b1;
        end
      end
      S_STREAM: begin
        if (clear) begin
          // word on offer this cycle is dropped even if out_ready=1
          state_d = S_IDLE;
          pix_d   = '0;
          col_d   = '0;
          zero    = 1'b1;
        end else if (out_ready) begin
          if (last_word) begin
            state_d = S_DONE;
            pix_d   = '0;
            col_d   = '0;
            zero    = 1'b1;
          end else if (last_pix) begin
            pix_d = '0;
            col_d = col_q + 4'd1;
            load  = 1'b1;
          end else begin
            pix_d = pix_q + 16'd4;
            load  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        pix_d   = '0;
        col_d   = '0;
        zero    = 1'b1;
      end
    endcase
  end

  // Word mux addressed by the *next* indices so out_data lines up with
  // pixel_iter/eigen_iter in the same cycle. Holding the register while
  // stalled keeps the offered word stable.
  always_comb begin
    word_sel = '0;
    for (int c = 0; c < COLS_SIZE; c++) begin
      for (int g = 0; g < NUM_GROUPS; g++) begin
        if (col_d == 4'(c) && pix_d == 16'(4 * g))
          word_sel = matrix_in[c][4*g +: 4];
      end
    end
  end

  always_comb begin
    data_d = data_q;
    if (load)      data_d = word_sel;
    else if (zero) data_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      col_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  assign busy       = (state_q == S_STREAM);
  assign out_valid  = busy;
  assign done       = (state_q == S_DONE);
  assign out_data   = data_q;
  assign pixel_iter = pix_q;
  assign eigen_iter = col_q;

endmodule

// File: tb/tb_p_reg_reader.sv
module tb_p_reg_reader;

  localparam int NP = 160;
  localparam int NC = 8;
  localparam int NG = NP / 4;
  localparam int NW = NC * NG;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, clear, out_ready;
  logic [NC-1:0][NP-1:0][7:0] mat;
  logic [31:0] out_data;
  logic        out_valid, busy, done;
  logic [15:0] pixel_iter;
  logic [3:0]  eigen_iter;

  // small corner-case instance
  logic s_start, s_ready;
  logic [0:0][3:0][7:0] s_mat;
  logic [31:0] s_data;
  logic        s_valid, s_busy, s_done;
  logic [15:0] s_pix;
  logic [3:0]  s_col;

  logic [7:0] bm [NC][NP];
  logic [7:0] sb [4];
  logic [31:0] got_words [NW];

  int n_tests = 0;
  int n_fail  = 0;

  always_comb begin
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        mat[c][p] = bm[c][p];
    for (int p = 0; p < 4; p++)
      s_mat[0][p] = sb[p];
  end

  p_reg_reader #(.NUM_PIXELS(NP), .COLS_SIZE(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear), .matrix_in(mat),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .pixel_iter(pixel_iter), .eigen_iter(eigen_iter), .busy(busy), .done(done)
  );

  p_reg_reader #(.NUM_PIXELS(4), .COLS_SIZE(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .clear(1'b0), .matrix_in(s_mat),
    .out_data(s_data), .out_valid(s_valid), .out_ready(s_ready),
    .pixel_iter(s_pix), .eigen_iter(s_col), .busy(s_busy), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: word n covers column n/NG, pixels 4*(n%NG)..+3, byte 0 low.
  function automatic logic [31:0] ref_word(input int n);
    int c, p;
    c = n / NG;
    p = (n % NG) * 4;
    return {bm[c][p+3], bm[c][p+2], bm[c][p+1], bm[c][p]};
  endfunction

  task automatic fill_pattern();
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        bm[c][p] = 8'((c * 16 + p) & 8'hFF);
  endtask

  // Pulse start; returns on the negedge after the start edge.
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consume words starting at index n0 until out_valid drops or n == stop_n.
  // Called on a negedge with the DUT streaming; returns on a negedge.
  task automatic run_words(input bit rnd, input int n0, input int stop_n,
                           input int start_at, output int n);
    bit r, stalled;
    logic [31:0] prev;
    n = n0;
    stalled = 1'b0;
    prev = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (!out_valid) return;
      if (n >= NW) begin
        chk("too_many_words", 32'(n), 32'(NW - 1));
        return;
      end
      chk("word", out_data, ref_word(n));
      chk("pixel_iter", 32'(pixel_iter), 32'((n % NG) * 4));
      chk("eigen_iter", 32'(eigen_iter), 32'(n / NG));
      if (stalled) chk("stall_stable", out_data, prev);
      got_words[n] = out_data;
      if (n == stop_n) return;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      start = (n == start_at);
      prev = out_data;
      stalled = !r;
      @(negedge clk);
      start = 1'b0;
      if (r) n++;
    end
    chk("stream_timeout", 32'(n), 32'(NW));
  endtask

  // Check the tail of a complete stream: DONE for one cycle, then IDLE.
  task automatic check_tail(input string tag, input int n);
    int dcount;
    chk({tag, "_count"}, 32'(n), 32'(NW));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_valid_off"}, 32'(out_valid), 32'd0);
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk({tag, "_done_once"}, 32'(dcount), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; clear = 1'b0; out_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0;
    fill_pattern();
    for (int p = 0; p < 4; p++) sb[p] = 8'($urandom_range(0, 255));
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_data", out_data, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pix", 32'(pixel_iter), 32'd0);
    chk("rst_col", 32'(eigen_iter), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // full stream, ready held high
    out_ready = 1'b1;
    do_start();
    chk("first_valid", 32'(out_valid), 32'd1);
    run_words(1'b0, 0, -1, -1, n);
    check_tail("full", n);
    chk("word0", got_words[0], 32'h03020100);
    chk("word40", got_words[40], 32'h13121110);

    // random backpressure
    do_start();
    run_words(1'b1, 0, -1, -1, n);
    check_tail("bp", n);
    chk("bp_word0", got_words[0], 32'h03020100);

    // abort after 50 transfers
    out_ready = 1'b1;
    do_start();
    run_words(1'b0, 0, 50, -1, n);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_valid", 32'(out_valid), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_pix", 32'(pixel_iter), 32'd0);
    @(negedge clk);
    chk("clr_done2", 32'(done), 32'd0);
    do_start();
    chk("restart_word", out_data, 32'h03020100);
    run_words(1'b0, 0, -1, -1, n);
    check_tail("restart", n);

    // reset mid-stream at word 100
    out_ready = 1'b1;
    do_start();
    run_words(1'b0, 0, 100, -1, n);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_data", out_data, 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_idx", {pixel_iter, 12'd0, eigen_iter}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mrst_quiet", 32'(out_valid), 32'd0);
    end

    // start while busy is ignored
    do_start();
    run_words(1'b0, 0, -1, 10, n);
    check_tail("busy_start", n);

    // live sampling: change a not-yet-streamed byte mid-stream
    out_ready = 1'b1;
    do_start();
    run_words(1'b0, 0, 5, -1, n);
    bm[2][9] = 8'hA5;
    run_words(1'b0, 5, -1, -1, n);
    chk("live_word", got_words[2 * NG + 2], {bm[2][11], bm[2][10], 8'hA5, bm[2][8]});
    check_tail("live", n);
    fill_pattern();

    // corner case: one column of four pixels
    s_ready = 1'b1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_valid", 32'(s_valid), 32'd1);
    chk("small_word", s_data, {sb[3], sb[2], sb[1], sb[0]});
    @(negedge clk);
    chk("small_done", 32'(s_done), 32'd1);
    chk("small_valid_off", 32'(s_valid), 32'd0);
    @(negedge clk);
    chk("small_idle", {30'd0, s_done, s_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
